// File: rtl/jtag_pkg.sv
// jtag_pkg: IEEE 1149.1 TAP state encodings and next-state function shared by the chain mux.
package jtag_pkg;
   localparam int STRETCH_W = 8;
   typedef enum logic [3:0] {
      EX2_DR   = 4'h0,
      EX1_DR   = 4'h1,
      SHIFT_DR = 4'h2,
      PAUSE_DR = 4'h3,
      SEL_IR   = 4'h4,
      UPD_DR   = 4'h5,
      CAP_DR   = 4'h6,
      SEL_DR   = 4'h7,
      EX2_IR   = 4'h8,
      EX1_IR   = 4'h9,
      SHIFT_IR = 4'hA,
      PAUSE_IR = 4'hB,
      RTI      = 4'hC,
      UPD_IR   = 4'hD,
      CAP_IR   = 4'hE,
      TLR      = 4'hF
   } tap_state_e;
   function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
      case (s)
         RTI, UPD_DR, UPD_IR: return tms ? SEL_DR : RTI;
         SEL_DR:              return tms ? SEL_IR : CAP_DR;
         CAP_DR, SHIFT_DR:    return tms ? EX1_DR : SHIFT_DR;
         EX1_DR:              return tms ? UPD_DR : PAUSE_DR;
         PAUSE_DR:            return tms ? EX2_DR : PAUSE_DR;
         EX2_DR:              return tms ? UPD_DR : SHIFT_DR;
         SEL_IR:              return tms ? TLR : CAP_IR;
         CAP_IR, SHIFT_IR:    return tms ? EX1_IR : SHIFT_IR;
         EX1_IR:              return tms ? UPD_IR : PAUSE_IR;
         PAUSE_IR:            return tms ? EX2_IR : PAUSE_IR;
         EX2_IR:              return tms ? UPD_IR : SHIFT_IR;
         default:             return tms ? TLR : RTI;
      endcase
   endfunction
endpackage

// File: rtl/jtag_tap_tracker.sv
// jtag_tap_tracker: shadows the target TAP controller from synchronised TCK rising-edge strobes.
module jtag_tap_tracker
   import jtag_pkg::*;
(
   input  logic       CLK,
   input  logic       nRST,
   input  logic       tck_rise,
   input  logic       tms,
   input  logic       force_tlr,
   output tap_state_e state
);
   tap_state_e state_q, state_d;
   always_comb state_d = force_tlr ? TLR : tck_rise ? tap_next(state_q, tms) : state_q;
   always_ff @(posedge CLK) state_q <= !nRST ? TLR : state_d;
   assign state = state_q;
endmodule

// File: rtl/jtag_chain_mux.sv
// jtag_chain_mux: routes one FTDI JTAG port to one of NUM_CH target chains, switching only
// when the tracked TAP is idle (TLR/RTI), TCK is low and any nTRST stretch has expired.
module jtag_chain_mux
   import jtag_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int SEL_W    = $clog2(NUM_CH),
   parameter int TRST_MIN = 16
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              FT_TDI,
   input  logic              FT_TCK,
   input  logic              FT_TMS,
   input  logic              FT_nTRST_OUT,
   output logic              FT_TDO,
   input  logic [SEL_W-1:0]  SEL,
   input  logic [NUM_CH-1:0] TDO,
   output logic [NUM_CH-1:0] TCK,
   output logic [NUM_CH-1:0] TDI,
   output logic [NUM_CH-1:0] TMS,
   output logic [NUM_CH-1:0] nTRST,
   output logic [SEL_W-1:0]  ACT_CH,
   output logic              SWITCH_PEND,
   output logic              SEL_ERR,
   output logic [3:0]        TAP_STATE
);
   logic [1:0] tck_sync_q, tck_sync_d, tms_sync_q, tms_sync_d, trst_sync_q, trst_sync_d;
   logic tck_prev_q, tck_prev_d, trst_prev_q, trst_prev_d;
   logic [STRETCH_W-1:0] cnt_q, cnt_d;
   logic [SEL_W-1:0] act_ch_q, act_ch_d;
   logic pend_q, pend_d, sel_err_q, sel_err_d;
   logic [NUM_CH-1:0] ntrst_q, ntrst_d;
   logic tck_rise, trst_fall, sel_ok, go;
   tap_state_e tap_state;
   // Data path is purely combinational; the synchronisers only feed the tracking logic.
   always_comb begin
      TCK = '0;
      TDI = '1;
      TMS = '1;
      TCK[act_ch_q] = FT_TCK;
      TDI[act_ch_q] = FT_TDI;
      TMS[act_ch_q] = FT_TMS;
      FT_TDO = TDO[act_ch_q];
   end
   always_comb begin
      tck_sync_d = {tck_sync_q[0], FT_TCK};
      tms_sync_d = {tms_sync_q[0], FT_TMS};
      trst_sync_d = {trst_sync_q[0], FT_nTRST_OUT};
      tck_prev_d = tck_sync_q[1];
      trst_prev_d = trst_sync_q[1];
      tck_rise = tck_sync_q[1] & ~tck_prev_q;
      trst_fall = trst_prev_q & ~trst_sync_q[1];
      cnt_d = trst_fall ? STRETCH_W'(TRST_MIN) : cnt_q - STRETCH_W'(cnt_q != '0);
      sel_ok = {1'b0, SEL} < (SEL_W+1)'(NUM_CH);
      go = pend_q & sel_ok & (tap_state == TLR || tap_state == RTI) & ~tck_sync_q[1] & ~tck_rise & (cnt_q == '0);
      act_ch_d = go ? SEL : act_ch_q;
      pend_d = sel_ok & (SEL != act_ch_d);
      sel_err_d = ~sel_ok;
      ntrst_d = '1;
      ntrst_d[act_ch_d] = trst_sync_q[1] & (cnt_d == '0);
   end
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         tck_sync_q <= '0;
         tms_sync_q <= '0;
         trst_sync_q <= '1;
         tck_prev_q <= 1'b0;
         trst_prev_q <= 1'b1;
         cnt_q <= '0;
         act_ch_q <= '0;
         pend_q <= 1'b0;
         sel_err_q <= 1'b0;
         ntrst_q <= '1;
      end else begin
         tck_sync_q <= tck_sync_d;
         tms_sync_q <= tms_sync_d;
         trst_sync_q <= trst_sync_d;
         tck_prev_q <= tck_prev_d;
         trst_prev_q <= trst_prev_d;
         cnt_q <= cnt_d;
         act_ch_q <= act_ch_d;
         pend_q <= pend_d;
         sel_err_q <= sel_err_d;
         ntrst_q <= ntrst_d;
      end
   end
   jtag_tap_tracker u_tap (
      .CLK       (CLK),
      .nRST      (nRST),
      .tck_rise  (tck_rise),
      .tms       (tms_sync_q[1]),
      .force_tlr (~trst_sync_q[1]),
      .state     (tap_state)
   );
   assign ACT_CH = act_ch_q;
   assign SWITCH_PEND = pend_q;
   assign SEL_ERR = sel_err_q;
   assign nTRST = ntrst_q;
   assign TAP_STATE = tap_state;
endmodule

// File: doc/jtag_chain_mux.md
JTAG_CHAIN_MUX -- requirements
Module: jtag_chain_mux

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of target JTAG channels (legal 2..8).
REQ-002 SHALL have parameter SEL_W, default $clog2(NUM_CH): width of the channel-select field.
REQ-003 SHALL have parameter TRST_MIN, default 16: minimum nTRST low time, in CLK cycles (legal 1..255).
REQ-004 Port CLK, input, 1: sole clock; must be at least 4x the FT_TCK frequency.
REQ-005 Port nRST, input, 1: reset, synchronous to CLK, active-low.
REQ-006 Port FT_TDI / FT_TCK / FT_TMS / FT_nTRST_OUT, inputs, 1 each: JTAG signals from the FTDI side.
REQ-007 Port FT_TDO, output, 1: TDO returned to the FTDI side.
REQ-008 Port SEL, input, SEL_W: requested target channel (level).
REQ-009 Port TDO, input, NUM_CH: per-channel target TDO.
REQ-010 Port TCK / TDI / TMS / nTRST, outputs, NUM_CH each: per-channel target JTAG drive.
REQ-011 Port ACT_CH, output, SEL_W: currently routed channel.
REQ-012 Port SWITCH_PEND, output, 1: high while a valid SEL differs from ACT_CH.
REQ-013 Port SEL_ERR, output, 1: registered; high while SEL >= NUM_CH.
REQ-014 Port TAP_STATE, output, 4: tracked TAP state, IEEE 1149.1 encoding (TLR=4'hF, RTI=4'hC, SelDR=4'h7, SelIR=4'h4, ...).

Function
REQ-015 Active channel SHALL be driven combinationally: TCK=FT_TCK, TDI=FT_TDI, TMS=FT_TMS; FT_TDO=TDO[ACT_CH]; zero CLK latency on the data path.
REQ-016 Inactive channels SHALL drive TCK=0, TDI=1, TMS=1, nTRST=1.
REQ-017 FT_TCK, FT_TMS and FT_nTRST_OUT SHALL each pass through a 2-flop synchroniser for tracking logic only.
REQ-018 A rising edge of synchronised TCK SHALL advance the 16-state TAP FSM using synchronised TMS; TAP_STATE updates 1 CLK after edge detection.
REQ-019 Synchronised FT_nTRST_OUT low SHALL force TAP_STATE to TLR on the next CLK edge, overriding TCK edges.
REQ-020 nTRST[ACT_CH] SHALL be registered; low while synchronised FT_nTRST_OUT is low, and held low for TRST_MIN CLK cycles after it falls, whichever ends later.
REQ-021 Stretch counter SHALL be 8 bits; it reloads TRST_MIN on every new falling edge and saturates at 0.
REQ-022 A switch SHALL take effect on the CLK edge where SWITCH_PEND=1, TAP_STATE is TLR or RTI, synchronised TCK=0, no TCK rising edge is detected, and the stretch counter is 0.
REQ-023 While SEL >= NUM_CH: SEL_ERR=1, SWITCH_PEND=0, ACT_CH unchanged.
REQ-024 If SEL returns to ACT_CH before the switch is taken, SWITCH_PEND SHALL clear with no switch.
REQ-025 TAP_STATE SHALL NOT be reset by a switch; the host must re-sync the new chain (e.g. 5x TMS=1).
REQ-026 If SEL changes while pending, the switch target SHALL be SEL as sampled on the switch cycle.

Reset
REQ-027 On CLK with nRST=0: ACT_CH=0, TAP_STATE=TLR, SWITCH_PEND=0, SEL_ERR=0, stretch counter=0, all nTRST=1, synchronisers=0 (FT_nTRST_OUT synchroniser=1).
REQ-028 Reset mid-stretch or mid-scan SHALL abort all tracking; channel 0 passthrough SHALL be live from the first cycle after reset.

Structure
REQ-029 A shared package jtag_pkg SHALL hold the 16 TAP state encodings and the next-state function.
REQ-030 The TAP tracker SHALL be a sub-module, jtag_tap_tracker (inputs: CLK, nRST, TCK edge strobe, TMS, force-TLR; output: state).
REQ-031 The routing mux, the stretch counter and the switch controller SHALL live in jtag_chain_mux.

Verification
REQ-032 Reset, then FT_TCK toggles with TMS=0: TCK[0] follows FT_TCK, TCK[1]=0, TAP_STATE TLR->RTI after the first edge.
REQ-033 In Shift-DR (TMS 1,0,0 from RTI), set SEL=1: SWITCH_PEND=1, ACT_CH=0 during the shift; after TMS 1,1,0 back to RTI with TCK low, ACT_CH=1 and FT_TDO follows TDO[1].
REQ-034 FT_nTRST_OUT low for 3 CLK with TRST_MIN=16: nTRST[0] low for 16 cycles (+ synchroniser delay), TAP_STATE=TLR; a SEL change meanwhile waits until the counter reaches 0.
REQ-035 NUM_CH=3, SEL=3: SEL_ERR=1, SWITCH_PEND=0, ACT_CH held; then SEL=2 in RTI: switch completes.
REQ-036 From any state, 5 TCK edges with TMS=1: TAP_STATE=TLR; the walk checks all 16 transitions against jtag_pkg.
REQ-037 Assert nRST low during Shift-IR with a pending switch: next cycle ACT_CH=0, TAP_STATE=4'hF, SWITCH_PEND=0.
